// File: rtl/sh7604_dbus_responder_pkg.sv
// Shared SH7604 DBUS definitions: FSM states, byte-lane constants and the per-beat record.
package sh7604_dbus_responder_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WSTATE,
      MEM,
      ACK,
      REL
   } DBUS_STATE_t;

   localparam logic [3:0] BA_NONE = 4'b0000;
   localparam logic [3:0] BA_LONG = 4'b1111;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  ba;
      logic        we;
   } beat_t;

   // Longword beats are forced onto a 4-byte boundary; narrower accesses keep the byte address.
   function automatic beat_t make_beat(input logic [31:0] a, input logic [31:0] d,
                                       input logic [3:0] ba, input logic we);
      beat_t b;
      b.addr = (ba == BA_LONG) ? {a[31:2], 2'b00} : a;
      b.data = d;
      b.ba   = ba;
      b.we   = we;
      return b;
   endfunction

endpackage

// File: rtl/sh7604_dbus_waitgen.sv
// Wait-state and memory-timeout counters; both advance only on CE_R.
// wait_done flags the last wait period, tout_done the last permitted MEM period.
module sh7604_dbus_waitgen #(
   parameter int MEM_TIMEOUT = 255
) (
   input  logic       CLK,
   input  logic       RST_N,
   input  logic       ce,
   input  logic       wait_load,
   input  logic [7:0] wait_val,
   input  logic       tout_run,
   output logic       wait_done,
   output logic       tout_done
);

   localparam int TW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);

   logic [7:0]    wait_cnt;
   logic [TW-1:0] tout_cnt;

   assign wait_done = (wait_cnt <= 8'd1);
   assign tout_done = (tout_cnt == TW'(MEM_TIMEOUT - 1));

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         wait_cnt <= '0;
         tout_cnt <= '0;
      end else if (ce) begin
         if (wait_load)
            wait_cnt <= wait_val;
         else if (wait_cnt != 8'd0)
            wait_cnt <= wait_cnt - 8'd1;
         // Restarts from zero on every MEM entry because any non-MEM period clears it.
         tout_cnt <= tout_run ? tout_cnt + TW'(1) : '0;
      end
   end

endmodule

// File: rtl/sh7604_dbus_responder.sv
// SH7604 DBUS responder: wait-state insertion, memory forwarding, ACK/error and bus release.
// DBUS_WAIT is combinational from DBUS_REQ; every other output comes from registered state.
module sh7604_dbus_responder
   import sh7604_dbus_responder_pkg::*;
#(
   parameter int WAIT_FIRST  = 2,
   parameter int WAIT_BURST  = 0,
   parameter int MEM_TIMEOUT = 255
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic        CE_R,
   input  logic        CE_F,
   input  logic [31:0] DBUS_A,
   input  logic [31:0] DBUS_DO,
   input  logic [3:0]  DBUS_BA,
   input  logic        DBUS_WE,
   input  logic        DBUS_REQ,
   input  logic        DBUS_BURST,
   input  logic        DBUS_LOCK,
   output logic [31:0] DBUS_DI,
   output logic        DBUS_WAIT,
   output logic        BSC_ACK,
   output logic        BUS_ERR,
   output logic [31:0] MEM_A,
   output logic [31:0] MEM_DO,
   output logic [3:0]  MEM_BE,
   output logic        MEM_WE,
   output logic        MEM_REQ,
   input  logic [31:0] MEM_DI,
   input  logic        MEM_RDY,
   input  logic        EXT_BREQ,
   output logic        EXT_BACK
);

   DBUS_STATE_t state;
   beat_t       beat;
   logic [1:0]  beats_left;
   logic [31:0] rd_reg;
   logic [31:0] di_hold;
   logic        lock_flag;
   logic        bus_err;
   logic        wait_load;
   logic [7:0]  wait_val;
   logic        wait_done;
   logic        tout_done;

   always_comb begin
      wait_load = 1'b0;
      wait_val  = 8'(WAIT_FIRST);
      if (CE_R && state == IDLE && DBUS_REQ) begin
         wait_load = 1'b1;
      end else if (CE_R && state == ACK && beats_left != 2'd0) begin
         wait_load = 1'b1;
         wait_val  = 8'(WAIT_BURST);
      end
   end

   sh7604_dbus_waitgen #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_waitgen (
      .CLK       (CLK),
      .RST_N     (RST_N),
      .ce        (CE_R),
      .wait_load (wait_load),
      .wait_val  (wait_val),
      .tout_run  (state == MEM),
      .wait_done (wait_done),
      .tout_done (tout_done)
   );

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state      <= IDLE;
         beat       <= '{addr: '0, data: '0, ba: BA_NONE, we: 1'b0};
         beats_left <= 2'd0;
         rd_reg     <= '0;
         di_hold    <= '0;
         lock_flag  <= 1'b0;
         bus_err    <= 1'b0;
      end else begin
         if (CE_F)
            di_hold <= rd_reg;
         if (CE_R) begin
            bus_err <= 1'b0;
            case (state)
               IDLE: begin
                  if (!DBUS_LOCK)
                     lock_flag <= 1'b0;
                  // A request beats a same-cycle bus request; a lock dropped now no longer blocks release.
                  if (DBUS_REQ) begin
                     beat       <= make_beat(DBUS_A, DBUS_DO, DBUS_BA, DBUS_WE);
                     beats_left <= DBUS_BURST ? 2'd3 : 2'd0;
                     state      <= (WAIT_FIRST == 0) ? MEM : WSTATE;
                  end else if (EXT_BREQ && !(lock_flag && DBUS_LOCK)) begin
                     state <= REL;
                  end
               end
               WSTATE: if (wait_done) state <= MEM;
               MEM: begin
                  if (MEM_RDY) begin
                     rd_reg <= MEM_DI;
                     state  <= ACK;
                  end else if (tout_done) begin
                     rd_reg  <= '1;
                     bus_err <= 1'b1;
                     state   <= ACK;
                  end
               end
               ACK: begin
                  lock_flag <= DBUS_LOCK;
                  if (beats_left != 2'd0) begin
                     beats_left <= beats_left - 2'd1;
                     beat       <= make_beat(DBUS_A, DBUS_DO, DBUS_BA, beat.we);
                     state      <= (WAIT_BURST == 0) ? MEM : WSTATE;
                  end else begin
                     state <= IDLE;
                  end
               end
               REL: if (!EXT_BREQ) state <= IDLE;
               default: state <= IDLE;
            endcase
         end
      end
   end

   assign DBUS_WAIT = RST_N & DBUS_REQ & (state != ACK);
   assign BSC_ACK   = (state == ACK);
   assign BUS_ERR   = bus_err;
   assign DBUS_DI   = di_hold;
   assign EXT_BACK  = (state == REL);
   assign MEM_REQ   = (state == MEM);
   assign MEM_A     = MEM_REQ ? beat.addr : '0;
   assign MEM_DO    = MEM_REQ ? beat.data : '0;
   assign MEM_BE    = MEM_REQ ? beat.ba   : '0;
   assign MEM_WE    = MEM_REQ & beat.we;

endmodule
